// File: rtl/axi_lite_imem_rd_slave.sv
// AXI-lite read-only responder that serves instruction fetches from a word memory.
// The response latency is fixed or LFSR-driven, and the memory is preloaded through a backdoor port.
module axi_lite_imem_rd_slave #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LAT_MODE    = 0,
    parameter int          FIXED_LAT   = 1,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5,
    parameter logic [7:0]  LAT_MASK    = 8'h07
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [31:0] i_axi_araddr,
    input  logic        i_axi_arvalid,
    output logic        o_axi_arready,
    output logic [31:0] o_axi_rdata,
    output logic [1:0]  o_axi_rresp,
    output logic        o_axi_rvalid,
    input  logic        i_axi_rready,
    input  logic        i_init_we,
    input  logic [31:0] i_init_addr,
    input  logic [31:0] i_init_data
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [7:0]  lfsr, cnt, cnt_nxt, lat;
    logic [31:0] addr_q, dec_addr, rdata_nxt;
    logic [1:0]  rresp_nxt;
    logic        capture;
    logic [31:0] mem [DEPTH_WORDS];

    // Misalignment is checked first; addresses below the base wrap to large offsets.
    function automatic logic [1:0] decode_resp(input logic [31:0] a);
        if (a[1:0] != 2'b00)
            return 2'b10;
        if ((a - ADDR_BASE) >= SPAN)
            return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return AW'((a - ADDR_BASE) >> 2);
    endfunction

    assign lat           = (LAT_MODE == 1) ? (lfsr & LAT_MASK) : 8'(FIXED_LAT);
    assign o_axi_arready = (state == IDLE);
    assign o_axi_rvalid  = (state == RESP);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        dec_addr  = addr_q;
        case (state)
            IDLE: begin
                // A zero-latency accept captures the response straight from the bus address.
                dec_addr = i_axi_araddr;
                if (i_axi_arvalid) begin
                    cnt_nxt = lat;
                    if (lat != 8'd0) begin
                        state_nxt = WAIT;
                    end else begin
                        state_nxt = RESP;
                        capture   = 1'b1;
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 8'd1;
                if (cnt == 8'd1) begin
                    state_nxt = RESP;
                    capture   = 1'b1;
                end
            end
            RESP: begin
                if (i_axi_rready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        rresp_nxt = decode_resp(dec_addr);
        rdata_nxt = (rresp_nxt == 2'b00) ? mem[word_idx(dec_addr)] : 32'd0;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            lfsr        <= LFSR_SEED;
            o_axi_rdata <= 32'd0;
            o_axi_rresp <= 2'b00;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (capture) begin
                o_axi_rdata <= rdata_nxt;
                o_axi_rresp <= rresp_nxt;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (state == IDLE && i_axi_arvalid)
            addr_q <= i_axi_araddr;
    end

    // Backdoor writes land at the edge, so a same-cycle response capture still sees old data.
    always_ff @(posedge i_clock) begin
        if (i_init_we && i_init_addr[1:0] == 2'b00 && (i_init_addr - ADDR_BASE) < SPAN)
            mem[word_idx(i_init_addr)] <= i_init_data;
    end

endmodule
